// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package ps2_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE_SKIP
    } state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam int unsigned PAUSE_SKIP_LEN = 7;
    localparam int unsigned SKIP_W         = 3;

    // Keyboard status/handshake bytes that never form part of a key event.
    localparam logic [7:0] KB_NULL   = 8'h00;
    localparam logic [7:0] KB_BAT_OK = 8'hAA;
    localparam logic [7:0] KB_ACK    = 8'hFA;
    localparam logic [7:0] KB_RESEND = 8'hFE;
    localparam logic [7:0] KB_ERROR  = 8'hFF;

    function automatic logic is_discard(input logic [7:0] b);
        return (b == KB_NULL) || (b == KB_BAT_OK) || (b == KB_ACK) ||
               (b == KB_RESEND) || (b == KB_ERROR);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_EXT) || (b == PFX_BRK) || (b == PFX_PAUSE);
    endfunction

    // State a prefix byte selects when seen from IDLE.
    function automatic state_e prefix_state(input logic [7:0] b);
        state_e s;
        s = PAUSE_SKIP;
        if (b == PFX_EXT) begin
            s = EXT;
        end else if (b == PFX_BRK) begin
            s = BRK;
        end
        return s;
    endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: folds E0/F0/E1 prefixes into one key event per keystroke.
// Define KEY_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of a held key.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] dout,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       err,
    output logic       busy
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [7:0]          code_q, code_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                err_q, err_d;

    logic                emit;
    logic [7:0]          ev_code;
    logic                ev_ext;
    logic                ev_brk;
    logic                suppress;

`ifdef KEY_TYPEMATIC_FILTER_EN
    logic                held_q, held_d;
    logic                tm_ext_q, tm_ext_d;
    logic [7:0]          tm_code_q, tm_code_d;
`endif

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        emit     = 1'b0;
        ev_code  = dout;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        suppress = 1'b0;

        if (rx_done_tick) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (is_prefix(dout)) begin
                        state_d = prefix_state(dout);
                    end else begin
                        emit = !is_discard(dout);
                    end
                end
                EXT: begin
                    if (dout == PFX_BRK) begin
                        state_d = EXT_BRK;
                    end else if (is_prefix(dout)) begin
                        err_d   = 1'b1;
                        state_d = prefix_state(dout);
                    end else begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    if (is_prefix(dout)) begin
                        err_d   = 1'b1;
                        state_d = prefix_state(dout);
                    end else begin
                        emit    = 1'b1;
                        ev_brk  = 1'b1;
                        ev_ext  = (state_q == EXT_BRK);
                        state_d = IDLE;
                    end
                end
                PAUSE_SKIP: begin
                    if (skip_q == SKIP_W'(1)) begin
                        emit    = 1'b1;
                        ev_code = PFX_PAUSE;
                        state_d = IDLE;
                    end else begin
                        skip_d = skip_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d == PAUSE_SKIP && state_q != PAUSE_SKIP) begin
                skip_d = SKIP_W'(PAUSE_SKIP_LEN);
            end
        end else if (state_q != IDLE) begin
            // A received byte always takes precedence over expiry (handled above).
            if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

`ifdef KEY_TYPEMATIC_FILTER_EN
        held_d    = held_q;
        tm_ext_d  = tm_ext_q;
        tm_code_d = tm_code_q;
        // Pause has no break code, so it is kept out of the repeat record.
        if (emit && ev_code != PFX_PAUSE) begin
            if (ev_brk) begin
                if (held_q && tm_ext_q == ev_ext && tm_code_q == ev_code) begin
                    held_d = 1'b0;
                end
            end else if (held_q && tm_ext_q == ev_ext && tm_code_q == ev_code) begin
                suppress = 1'b1;
            end else begin
                held_d    = 1'b1;
                tm_ext_d  = ev_ext;
                tm_code_d = ev_code;
            end
        end
`endif

        valid_d = emit && !suppress;
        code_d  = valid_d ? ev_code : code_q;
        ext_d   = valid_d ? ev_ext  : ext_q;
        brk_d   = valid_d ? ev_brk  : brk_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            skip_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= 8'h00;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef KEY_TYPEMATIC_FILTER_EN
            held_q    <= 1'b0;
            tm_ext_q  <= 1'b0;
            tm_code_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            err_q     <= err_d;
`ifdef KEY_TYPEMATIC_FILTER_EN
            held_q    <= held_d;
            tm_ext_q  <= tm_ext_d;
            tm_code_q <= tm_code_d;
`endif
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_ext   = ext_q;
    assign key_break = brk_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule
